fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Sequences the 128-word instruction ROM: owns the program counter, drives the ROM address, and registers each fetched word into the IF/ID pipeline register.
- Handles start, stall, branch/jump redirect with flush, and end-of-program halt for the MIPS pipeline.
- Sits between instruction_memory (combinational read) and the decode stage.

Parameters:
- ADDR_W, 7, ROM word-address width (128 words).
- LAST_ADDR, 127, last word address fetched before halting.
- NOP_WORD, 32'h8000_0000, bubble word inserted on flush/reset (pipeline NOP encoding).
- HALT_WORD, 32'hFFFF_FFFF, fetched word that stops sequencing.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins fetching at address 0 from IDLE or HALTED.
- stall  in  1  decode hazard; hold PC and IF/ID.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_pc  in  ADDR_W  redirect target word address.
- imem_addr  out  ADDR_W  address to instruction_memory; equals pc.
- imem_instr  in  32  word returned combinationally by instruction_memory.
- if_id_instr  out  32  registered instruction.
- if_id_pc  out  ADDR_W  registered address of if_id_instr.
- if_id_valid  out  1  if_id_instr is a real fetched word.
- busy  out  1  high in RUN.
- halted  out  1  high in HALTED.

Behaviour:
- All inputs are interface decisions as stated: one clock, synchronous active-high rst.
- Reset: state=IDLE, pc=0, if_id_instr=NOP_WORD, if_id_pc=0, if_id_valid=0, busy=0, halted=0. A reset asserted mid-RUN takes effect at that edge, with no partial update.
- States are IDLE, RUN and HALTED.
- IDLE: pc held at 0 and if_id_valid=0. start -> RUN.
- RUN: each cycle, priority is redirect > stall > normal.
  - redirect_valid: pc<=redirect_pc; if_id_instr<=NOP_WORD; if_id_valid<=0. Redirect wins over a simultaneous stall.
  - stall (no redirect): pc, if_id_* hold.
  - normal: if_id_instr<=imem_instr; if_id_pc<=pc; if_id_valid<=1; pc<=pc+1.
- Latency: one cycle from address to if_id_instr.
- Halt condition (normal cycle only): imem_instr==HALT_WORD or pc==LAST_ADDR.
  - On HALT_WORD: the word is not forwarded (if_id_instr<=NOP_WORD, valid<=0), pc holds, and state goes to HALTED.
  - On pc==LAST_ADDR with a non-halt word: the word is forwarded normally, pc holds (no wrap to 0), and state goes to HALTED.
- HALTED: if_id_instr<=NOP_WORD, valid<=0, pc held; stall and redirect are ignored. start -> pc<=0, RUN.
- start while in RUN is ignored.
- Arithmetic: pc+1 is ADDR_W bits. Wrap is unreachable because of the LAST_ADDR halt; a redirect to any address is legal.
- busy = (state==RUN); halted = (state==HALTED). Both are registered-state decodes.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt, stall_cnt and flush_cnt, each 16 bits. They count normal, stall and redirect RUN cycles respectively, saturate at 16'hFFFF, and clear on rst and on start.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg holds ADDR_W, NOP_WORD, HALT_WORD and the state enum (IDLE, RUN, HALTED).
- Natural sub-module: fetch_pc_reg, the PC register with the redirect/stall/increment mux. The FSM and IF/ID register stay in the top module.
- Perf counters live inline under the macro.

Test Plan:
- Reset then start with the ROM loaded with the team program -> if_id_instr sequence 0x8C010001, 0x8C020002, 0x8C030003 on cycles 1-3 after start, with if_id_pc 0,1,2 and valid=1.
- Stall held 3 cycles at pc=5 -> imem_addr=5 and if_id unchanged for 3 cycles; word 0x00220820 appears on the cycle after stall drops.
- redirect_valid with redirect_pc=9 asserted together with stall at pc=4 -> next cycle pc=9, if_id_instr=0x80000000, valid=0; then 0x00230820 with if_id_pc=9.
- HALT_WORD at address 21 -> after fetching 20, halted=1, pc=21, valid=0; a subsequent start restarts at address 0.
- LAST_ADDR=3 -> words 0-3 forwarded, then halted with pc=3 and no wrap. rst pulsed mid-RUN at pc=2 -> all outputs return to their reset values on the next edge.
- With FETCH_PERF_CNT_EN defined: run 10 normal, 2 stall and 1 redirect cycle -> fetch_cnt=10, stall_cnt=2, flush_cnt=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int          ADDR_W    = 7;
    localparam logic [31:0] NOP_WORD  = 32'h8000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_ZERO = 2'd1,
        PC_LOAD = 2'd2,
        PC_INC  = 2'd3
    } pc_op_e;

    function automatic logic is_halt_word(input logic [31:0] word);
        return (word == HALT_WORD);
    endfunction

    // Saturating increment used by the optional performance counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : (value + 16'd1);
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register; the fetch FSM selects hold, clear, redirect load or increment.
module fetch_pc_reg
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  pc_op_e            pc_op,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_r;

    // PC update selected by the sequencer each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= {ADDR_W{1'b0}};
        end else begin
            case (pc_op)
                PC_ZERO: pc_r <= {ADDR_W{1'b0}};
                PC_LOAD: pc_r <= redirect_pc;
                PC_INC:  pc_r <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                PC_HOLD: pc_r <= pc_r;
                default: pc_r <= pc_r;
            endcase
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: PC ownership, IF/ID register, start/stall/redirect/halt control.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall/flush cycle counters.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LAST_ADDR = 7'd127
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic              if_id_valid,
    output logic              busy,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt,
`endif
    output logic              halted
);

    fetch_state_e      state_r;
    fetch_state_e      state_next_s;
    pc_op_e            pc_op_s;
    logic [ADDR_W-1:0] pc_s;
    logic [31:0]       if_id_instr_r;
    logic [31:0]       instr_next_s;
    logic [ADDR_W-1:0] if_id_pc_r;
    logic [ADDR_W-1:0] ifpc_next_s;
    logic              if_id_valid_r;
    logic              valid_next_s;
    logic              fetch_ev_s;
    logic              stall_ev_s;
    logic              flush_ev_s;
    logic              clear_cnt_s;

    fetch_pc_reg u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .pc_op       (pc_op_s),
        .redirect_pc (redirect_pc),
        .pc          (pc_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state, PC operation and IF/ID next values; redirect beats stall beats fetch.
    always_comb begin
        state_next_s = state_r;
        pc_op_s      = PC_HOLD;
        instr_next_s = if_id_instr_r;
        ifpc_next_s  = if_id_pc_r;
        valid_next_s = if_id_valid_r;
        fetch_ev_s   = 1'b0;
        stall_ev_s   = 1'b0;
        flush_ev_s   = 1'b0;
        clear_cnt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                valid_next_s = 1'b0;
                if (start) begin
                    state_next_s = RUN;
                    pc_op_s      = PC_ZERO;
                    clear_cnt_s  = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_op_s      = PC_LOAD;
                    instr_next_s = NOP_WORD;
                    valid_next_s = 1'b0;
                    flush_ev_s   = 1'b1;
                end else if (stall) begin
                    stall_ev_s   = 1'b1;
                end else begin
                    fetch_ev_s   = 1'b1;
                    if (is_halt_word(imem_instr)) begin
                        // Halt word is swallowed, PC parks on it.
                        instr_next_s = NOP_WORD;
                        valid_next_s = 1'b0;
                        state_next_s = HALTED;
                    end else begin
                        instr_next_s = imem_instr;
                        ifpc_next_s  = pc_s;
                        valid_next_s = 1'b1;
                        if (pc_s == LAST_ADDR) begin
                            state_next_s = HALTED;
                        end else begin
                            pc_op_s = PC_INC;
                        end
                    end
                end
            end
            HALTED: begin
                instr_next_s = NOP_WORD;
                valid_next_s = 1'b0;
                if (start) begin
                    state_next_s = RUN;
                    pc_op_s      = PC_ZERO;
                    clear_cnt_s  = 1'b1;
                end else begin
                    state_next_s = HALTED;
                end
            end
            default: begin
                state_next_s = IDLE;
                pc_op_s      = PC_ZERO;
                instr_next_s = NOP_WORD;
                valid_next_s = 1'b0;
            end
        endcase
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_instr_r <= NOP_WORD;
            if_id_pc_r    <= {ADDR_W{1'b0}};
            if_id_valid_r <= 1'b0;
        end else begin
            if_id_instr_r <= instr_next_s;
            if_id_pc_r    <= ifpc_next_s;
            if_id_valid_r <= valid_next_s;
        end
    end

    assign imem_addr   = pc_s;
    assign if_id_instr = if_id_instr_r;
    assign if_id_pc    = if_id_pc_r;
    assign if_id_valid = if_id_valid_r;
    assign busy        = (state_r == RUN);
    assign halted      = (state_r == HALTED);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt_r;
    logic [15:0] stall_cnt_r;
    logic [15:0] flush_cnt_r;

    // Saturating RUN-cycle counters, cleared by reset and by an accepted start.
    always_ff @(posedge clk) begin
        if (rst || clear_cnt_s) begin
            fetch_cnt_r <= 16'd0;
            stall_cnt_r <= 16'd0;
            flush_cnt_r <= 16'd0;
        end else begin
            if (fetch_ev_s) fetch_cnt_r <= sat_inc16(fetch_cnt_r);
            if (stall_ev_s) stall_cnt_r <= sat_inc16(stall_cnt_r);
            if (flush_ev_s) flush_cnt_r <= sat_inc16(flush_cnt_r);
        end
    end

    assign fetch_cnt = fetch_cnt_r;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: vector table plus hand-written halt/reset sequences.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    typedef struct {
        logic        rst;
        logic        st;
        logic        sl;
        logic        rv;
        logic [6:0]  rpc;
        logic [6:0]  e_pc;
        logic [31:0] e_instr;
        logic [6:0]  e_ifpc;
        logic        e_ifpc_chk;
        logic        e_valid;
        logic        e_busy;
        logic        e_halted;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [6:0]  redirect_pc = 7'd0;
    logic [6:0]  imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_instr;
    logic [6:0]  if_id_pc;
    logic        if_id_valid;
    logic        busy;
    logic        halted;

    logic        start2 = 1'b0;
    logic [6:0]  imem_addr2;
    logic [31:0] imem_instr2;
    logic [31:0] if_id_instr2;
    logic [6:0]  if_id_pc2;
    logic        if_id_valid2;
    logic        busy2;
    logic        halted2;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt, stall_cnt, flush_cnt;
    logic [15:0] fetch_cnt2, stall_cnt2, flush_cnt2;
`endif

    int   errors = 0;
    int   checks = 0;
    vec_t exp_q[$];
    vec_t tbl[21];

    localparam logic [31:0] W0 = 32'h8C01_0001;
    localparam logic [31:0] W1 = 32'h8C02_0002;
    localparam logic [31:0] W2 = 32'h8C03_0003;
    localparam logic [31:0] W5 = 32'h0022_0820;
    localparam logic [31:0] W9 = 32'h0023_0820;

    // Team program image; unlisted addresses hold distinct non-halt fillers.
    function automatic logic [31:0] rom_word(input logic [6:0] a);
        case (a)
            7'd0:    return W0;
            7'd1:    return W1;
            7'd2:    return W2;
            7'd5:    return W5;
            7'd9:    return W9;
            7'd21:   return 32'hFFFF_FFFF;
            default: return 32'h0000_1000 + {25'd0, a};
        endcase
    endfunction

    assign imem_instr  = rom_word(imem_addr);
    assign imem_instr2 = rom_word(imem_addr2);

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_valid    (if_id_valid),
        .busy           (busy),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt      (fetch_cnt),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt),
`endif
        .halted         (halted)
    );

    fetch_sequencer #(.LAST_ADDR(7'd3)) dut_short (
        .clk            (clk),
        .rst            (rst),
        .start          (start2),
        .stall          (1'b0),
        .redirect_valid (1'b0),
        .redirect_pc    (7'd0),
        .imem_addr      (imem_addr2),
        .imem_instr     (imem_instr2),
        .if_id_instr    (if_id_instr2),
        .if_id_pc       (if_id_pc2),
        .if_id_valid    (if_id_valid2),
        .busy           (busy2),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt      (fetch_cnt2),
        .stall_cnt      (stall_cnt2),
        .flush_cnt      (flush_cnt2),
`endif
        .halted         (halted2)
    );

    function automatic vec_t mk(input logic r, input logic st, input logic sl, input logic rv,
                                input logic [6:0] rpc, input logic [6:0] pc, input logic [31:0] instr,
                                input logic [6:0] ifpc, input logic ifchk, input logic valid,
                                input logic bsy, input logic hlt);
        vec_t v;
        v.rst = r; v.st = st; v.sl = sl; v.rv = rv; v.rpc = rpc;
        v.e_pc = pc; v.e_instr = instr; v.e_ifpc = ifpc; v.e_ifpc_chk = ifchk;
        v.e_valid = valid; v.e_busy = bsy; v.e_halted = hlt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input logic r, input logic st, input logic sl, input logic rv, input logic [6:0] rpc);
        rst = r; start = st; stall = sl; redirect_valid = rv; redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle, queue its expectation, compare after the edge.
    task automatic step(input string tag, input vec_t v);
        vec_t e;
        exp_q.push_back(v);
        tick(v.rst, v.st, v.sl, v.rv, v.rpc);
        e = exp_q.pop_front();
        chk({tag, ".pc"},     {25'd0, imem_addr},   {25'd0, e.e_pc});
        chk({tag, ".instr"},  if_id_instr,          e.e_instr);
        chk({tag, ".valid"},  {31'd0, if_id_valid}, {31'd0, e.e_valid});
        chk({tag, ".busy"},   {31'd0, busy},        {31'd0, e.e_busy});
        chk({tag, ".halted"}, {31'd0, halted},      {31'd0, e.e_halted});
        if (e.e_ifpc_chk) chk({tag, ".if_id_pc"}, {25'd0, if_id_pc}, {25'd0, e.e_ifpc});
    endtask

    task automatic chk_short(input string tag, input logic [6:0] pc, input logic [31:0] instr,
                             input logic [6:0] ifpc, input logic valid, input logic hlt);
        chk({tag, ".pc"},       {25'd0, imem_addr2},   {25'd0, pc});
        chk({tag, ".instr"},    if_id_instr2,          instr);
        chk({tag, ".if_id_pc"}, {25'd0, if_id_pc2},    {25'd0, ifpc});
        chk({tag, ".valid"},    {31'd0, if_id_valid2}, {31'd0, valid});
        chk({tag, ".halted"},   {31'd0, halted2},      {31'd0, hlt});
    endtask

    initial begin
        //          rst   st    sl    rv    rpc    pc     instr                ifpc   chk   v     busy  halt
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 7'd0,  7'd0,  NOP_WORD,            7'd0,  1'b1, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd0,  NOP_WORD,            7'd0,  1'b1, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 7'd0,  7'd0,  NOP_WORD,            7'd0,  1'b1, 1'b0, 1'b1, 1'b0);
        tbl[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd1,  W0,                  7'd0,  1'b1, 1'b1, 1'b1, 1'b0);
        tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd2,  W1,                  7'd1,  1'b1, 1'b1, 1'b1, 1'b0);
        tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 7'd0,  7'd3,  W2,                  7'd2,  1'b1, 1'b1, 1'b1, 1'b0);
        tbl[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd4,  32'h0000_1003,       7'd3,  1'b1, 1'b1, 1'b1, 1'b0);
        tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd5,  32'h0000_1004,       7'd4,  1'b1, 1'b1, 1'b1, 1'b0);
        tbl[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 7'd0,  7'd5,  32'h0000_1004,       7'd4,  1'b1, 1'b1, 1'b1, 1'b0);
        tbl[9]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 7'd0,  7'd5,  32'h0000_1004,       7'd4,  1'b1, 1'b1, 1'b1, 1'b0);
        tbl[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 7'd0,  7'd5,  32'h0000_1004,       7'd4,  1'b1, 1'b1, 1'b1, 1'b0);
        tbl[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd6,  W5,                  7'd5,  1'b1, 1'b1, 1'b1, 1'b0);
        tbl[12] = mk(1'b0, 1'b0, 1'b0, 1'b1, 7'd2,  7'd2,  NOP_WORD,            7'd0,  1'b0, 1'b0, 1'b1, 1'b0);
        tbl[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd3,  W2,                  7'd2,  1'b1, 1'b1, 1'b1, 1'b0);
        tbl[14] = mk(1'b1, 1'b0, 1'b0, 1'b0, 7'd0,  7'd0,  NOP_WORD,            7'd0,  1'b1, 1'b0, 1'b0, 1'b0);
        tbl[15] = mk(1'b0, 1'b1, 1'b0, 1'b0, 7'd0,  7'd0,  NOP_WORD,            7'd0,  1'b1, 1'b0, 1'b1, 1'b0);
        tbl[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd1,  W0,                  7'd0,  1'b1, 1'b1, 1'b1, 1'b0);
        tbl[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd2,  W1,                  7'd1,  1'b1, 1'b1, 1'b1, 1'b0);
        tbl[18] = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd3,  W2,                  7'd2,  1'b1, 1'b1, 1'b1, 1'b0);
        tbl[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd4,  32'h0000_1003,       7'd3,  1'b1, 1'b1, 1'b1, 1'b0);
        tbl[20] = mk(1'b0, 1'b0, 1'b1, 1'b1, 7'd9,  7'd9,  NOP_WORD,            7'd0,  1'b0, 1'b0, 1'b1, 1'b0);

        @(posedge clk);
        #1;
        for (int i = 0; i < 21; i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // After the redirect to 9, run up to the halt word at 21.
        step("after_redirect", mk(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd10, W9, 7'd9, 1'b1, 1'b1, 1'b1, 1'b0));
        for (int a = 10; a <= 20; a++) begin
            step($sformatf("run%0d", a),
                 mk(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 7'(a + 1), rom_word(7'(a)), 7'(a), 1'b1, 1'b1, 1'b1, 1'b0));
        end
        step("halt_word",      mk(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd21, NOP_WORD, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        step("halted_ignore",  mk(1'b0, 1'b0, 1'b1, 1'b1, 7'd5, 7'd21, NOP_WORD, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        step("restart",        mk(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 7'd0,  NOP_WORD, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        step("restart_w0",     mk(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd1,  W0,       7'd0, 1'b1, 1'b1, 1'b1, 1'b0));
        step("restart_w1",     mk(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd2,  W1,       7'd1, 1'b1, 1'b1, 1'b1, 1'b0));
        step("midrun_rst",     mk(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0,  NOP_WORD, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0));

        // LAST_ADDR=3 instance: words 0..3 forwarded, then parked at 3.
        rst = 1'b0;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        chk("short.busy_after_start", {31'd0, busy2}, 32'd1);
        chk_short("short.start", 7'd0, NOP_WORD, 7'd0, 1'b0, 1'b0);
        for (int a = 0; a < 3; a++) begin
            @(posedge clk);
            #1;
            chk_short($sformatf("short.f%0d", a), 7'(a + 1), rom_word(7'(a)), 7'(a), 1'b1, 1'b0);
        end
        @(posedge clk);
        #1;
        chk_short("short.last", 7'd3, 32'h0000_1003, 7'd3, 1'b1, 1'b1);
        chk("short.busy_at_last", {31'd0, busy2}, 32'd0);
        @(posedge clk);
        #1;
        chk_short("short.nowrap", 7'd3, NOP_WORD, 7'd3, 1'b0, 1'b1);

`ifdef FETCH_PERF_CNT_EN
        tick(1'b0, 1'b1, 1'b0, 1'b0, 7'd0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        for (int i = 0; i < 2; i++)  tick(1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 7'd0);
        chk("perf.fetch_cnt", {16'd0, fetch_cnt}, 32'd10);
        chk("perf.stall_cnt", {16'd0, stall_cnt}, 32'd2);
        chk("perf.flush_cnt", {16'd0, flush_cnt}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
